core_if: RTL



---
 rtl/core_if_pkg.sv | 24 ++
 rtl/core_if_fifo.sv | 72 +++++++
 rtl/core_if.sv | 139 +++++++++++++
 3 files changed

// File: rtl/core_if_pkg.sv
// rtl/core_if_pkg.sv - shared constants, state encoding and entry layout for the fetch stage
package core_if_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DROP  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetches are word-aligned; low address bits of a redirect target are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/core_if_fifo.sv
// rtl/core_if_fifo.sv - synchronous prefetch FIFO with flush, push/pop and occupancy count
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush_i                  discard all entries (wins over push)
//   push_i, push_data_i      write one entry
//   pop_i                    drop the head entry
//   head_o                   head entry (valid when count_o != 0)
//   count_o                  number of stored entries
module core_if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/core_if.sv
// rtl/core_if.sv - instruction fetch stage: PC, memory req/ack fetch, prefetch FIFO, redirect
//
// Optional feature macro: CORE_IF_BYPASS_EN (empty-FIFO ack forwarded to inst_out same cycle).
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   jump_en_in, jump_addr_in         redirect from execute
//   mem_req_out, mem_addr_out        registered fetch request and word address
//   mem_ack_in, mem_rdata_in         request accepted, instruction valid this cycle
//   inst_valid_out, inst_ready_in    handshake towards IF/ID
//   inst_out, inst_addr_out          head instruction and its address (NOP/0 when empty)
module core_if
    import core_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if_state_e     state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;

    logic [CW-1:0] fifo_count;
    logic [63:0]   fifo_head_raw;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic          bypass;

    assign fifo_head  = fetch_entry_t'(fifo_head_raw);
    assign fifo_valid = (fifo_count != '0);
    assign pop        = fifo_valid && inst_ready_in;
    assign push_entry = '{addr: pc_q, inst: mem_rdata_in};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            IF_IDLE: begin
                if (jump_en_in) begin
                    pc_d    = align_word(jump_addr_in);
                    state_d = IF_FETCH;
                end else if (fifo_count < DEPTH_C) begin
                    state_d = IF_FETCH;
                end
            end
            IF_FETCH: begin
                if (jump_en_in) begin
                    // With a same-cycle ack the returned word is stale and simply not pushed.
                    pc_d    = align_word(jump_addr_in);
                    state_d = mem_ack_in ? IF_FETCH : IF_DROP;
                end else if (mem_ack_in) begin
                    pc_d = pc_q + 32'd4;
`ifdef CORE_IF_BYPASS_EN
                    if (!fifo_valid && inst_ready_in) bypass = 1'b1;
                    else                               push   = 1'b1;
`else
                    push = 1'b1;
`endif
                    state_d = ((fifo_count + CW'(push) - CW'(pop)) < DEPTH_C) ? IF_FETCH : IF_IDLE;
                end
            end
            IF_DROP: begin
                // The stale request stays on the bus until acked; a further jump
                // only retargets the pc. An ack completes the stale request either way.
                if (jump_en_in) pc_d = align_word(jump_addr_in);
                if (mem_ack_in) state_d = IF_FETCH;
            end
            default: state_d = IF_IDLE;
        endcase

        mem_req_d  = (state_d != IF_IDLE);
        mem_addr_d = (state_d == IF_FETCH) ? pc_d : mem_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req_out  = mem_req_q;
    assign mem_addr_out = mem_addr_q;

    always_comb begin
        inst_valid_out = fifo_valid;
        inst_out       = fifo_valid ? fifo_head.inst : INST_NOP;
        inst_addr_out  = fifo_valid ? fifo_head.addr : ZERO_WORD;
        if (bypass) begin
            inst_valid_out = 1'b1;
            inst_out       = mem_rdata_in;
            inst_addr_out  = pc_q;
        end
    end

    core_if_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (jump_en_in),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head_raw),
        .count_o     (fifo_count)
    );

endmodule
